i2c_status_target: RTL and testbench

- I2C target (slave) that lets an external I2C controller read the pet status (life, food, fun, rest, medicines, disease/death flags) and write one command byte.
- It is the responder end of the I2C protocol whose controller side drives the OLED and the ADS1115.
- Sits beside the game FSM: status vectors come in, cmd_valid/cmd_data go out.
- Runs on the system clock; SCL/SDA are oversampled. No clock stretching.

---
 rtl/i2c_tgt_pkg.sv | 39 +++
 rtl/i2c_status_target_if.sv | 9 +
 rtl/i2c_line_filter.sv | 40 ++++
 rtl/i2c_status_target.sv | 180 ++++++++++++++++++
 tb/tb_i2c_status_target.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_tgt_pkg.sv
// Shared definitions for the I2C status target: register map, FSM states,
// default identity constants and the status snapshot layout.
package i2c_tgt_pkg;

    localparam logic [2:0] REG_LIFE  = 3'd0;
    localparam logic [2:0] REG_FOOD  = 3'd1;
    localparam logic [2:0] REG_FUN   = 3'd2;
    localparam logic [2:0] REG_REST  = 3'd3;
    localparam logic [2:0] REG_FLAGS = 3'd4;
    localparam logic [2:0] REG_MEDS  = 3'd5;
    localparam logic [2:0] REG_CMD   = 3'd6;
    localparam logic [2:0] REG_ID    = 3'd7;

    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h42;
    localparam logic [7:0] DEV_ID_DEFAULT   = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    typedef struct packed {
        logic [6:0] life;
        logic [6:0] food;
        logic [6:0] fun;
        logic [6:0] rest;
        logic [6:0] medicines;
        logic       disease;
        logic       death;
    } status_t;

endpackage

// File: rtl/i2c_status_target_if.sv
// I2C pin bundle as seen by the target: raw SCL/SDA levels in, SDA pull-down out.
interface i2c_status_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample agreement filter for one I2C line,
// with single-cycle rise/fall strobes aligned to the filtered level change.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] hist;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            hist  <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            hist <= (hist << 1) | FILTER_LEN'(sync[1]);
            rise <= 1'b0;
            fall <= 1'b0;
            if ((&hist) && !level) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end else if (!(|hist) && level) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_status_target.sv
// I2C target exposing pet status registers (read) and one command register (write).
// Oversamples SCL/SDA on clk; never stretches the clock.
module i2c_status_target
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = I2C_ADDR_DEFAULT,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] DEV_ID     = DEV_ID_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    i2c_status_target_if.slave        bus,
    input  logic [6:0]                life,
    input  logic [6:0]                food,
    input  logic [6:0]                fun,
    input  logic [6:0]                rest,
    input  logic [6:0]                medicines,
    input  logic                      disease,
    input  logic                      death,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_data,
    output logic                      busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst_n(rst_n), .pin(bus.scl_in),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst_n(rst_n), .pin(bus.sda_in),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    state_t      state_q, state_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        oe_q, oe_d;
    logic        busy_d, cv_d, snap_ld;
    logic [7:0]  cmd_d, rd_byte, byte_in;
    status_t     snap_q;

    assign byte_in    = {shreg_q, sda};
    assign bus.sda_oe = oe_q;

    always_comb begin
        rd_byte = DEV_ID;
        case (ptr_q)
            REG_LIFE:  rd_byte = {1'b0, snap_q.life};
            REG_FOOD:  rd_byte = {1'b0, snap_q.food};
            REG_FUN:   rd_byte = {1'b0, snap_q.fun};
            REG_REST:  rd_byte = {1'b0, snap_q.rest};
            REG_FLAGS: rd_byte = {6'b0, snap_q.death, snap_q.disease};
            REG_MEDS:  rd_byte = {1'b0, snap_q.medicines};
            REG_CMD:   rd_byte = cmd_data;
            REG_ID:    rd_byte = DEV_ID;
            default:   rd_byte = DEV_ID;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        busy_d  = busy;
        cv_d    = 1'b0;
        cmd_d   = cmd_data;
        snap_ld = 1'b0;
        // Bus conditions override whatever the byte engine would do this cycle.
        if (sda_fall && scl) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (sda_rise && scl) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shreg_d = byte_in[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_d    = sda;
                        state_d = (byte_in[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    else if (scl_rise) begin
                        cnt_d = '0;
                        if (state_q == ST_WR_ACK) state_d = ST_WR_DATA;
                        else if (rw_q) begin
                            snap_ld = 1'b1;
                            state_d = ST_RD_DATA;
                        end else state_d = ST_WR_PTR;
                    end
                end
                ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_fall) oe_d = 1'b0;
                    else if (scl_rise) begin
                        shreg_d = byte_in[6:0];
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = ST_WR_ACK;
                            if (state_q == ST_WR_PTR) ptr_d = byte_in[2:0];
                            else begin
                                if (ptr_q == REG_CMD) begin
                                    cmd_d = byte_in;
                                    cv_d  = 1'b1;
                                end
                                ptr_d = ptr_q + 3'd1;
                            end
                        end
                    end
                end
                // The ACK-slot release and each data bit are both launched on SCL fall.
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = ST_RD_ACK;
                        end else oe_d = ~rd_byte[~cnt_q[2:0]];
                    end else if (scl_rise) cnt_d = cnt_q + 4'd1;
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (!sda) begin
                        ptr_d   = ptr_q + 3'd1;
                        cnt_d   = '0;
                        state_d = ST_RD_DATA;
                    end else state_d = ST_IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy      <= busy_d;
            cmd_valid <= cv_d;
            cmd_data  <= cmd_d;
            if (snap_ld) begin
                snap_q.life      <= life;
                snap_q.food      <= food;
                snap_q.fun       <= fun;
                snap_q.rest      <= rest;
                snap_q.medicines <= medicines;
                snap_q.disease   <= disease;
                snap_q.death     <= death;
            end
        end
    end

endmodule

// File: tb/tb_i2c_status_target.sv
// Bench for i2c_status_target: a bit-banged I2C controller with a register-level model.
module tb_i2c_status_target;

    localparam int FILTER_LEN = 3;
    localparam int Q          = 12;   // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctl_scl = 1'b1, ctl_sda = 1'b1;
    logic [6:0] life, food, fun, rest, medicines;
    logic disease, death;
    logic cmd_valid, busy;
    logic [7:0] cmd_data;

    i2c_status_target_if bus();
    wire sda_bus = ctl_sda & ~bus.sda_oe;
    assign bus.sda_in = sda_bus;
    assign bus.scl_in = ctl_scl;

    i2c_status_target #(.I2C_ADDR(7'h42), .FILTER_LEN(FILTER_LEN), .DEV_ID(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .life(life), .food(food), .fun(fun), .rest(rest), .medicines(medicines),
        .disease(disease), .death(death),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .busy(busy)
    );

    always #10 clk = ~clk;

    int tests = 0, fails = 0;
    int cv_cnt = 0;
    logic oe_seen = 1'b0;
    logic [2:0] m_ptr = 3'd0;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_snap [8];

    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (bus.sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctl_sda = 1'b1; wait_clk(Q);
        ctl_scl = 1'b1; wait_clk(Q);
        ctl_sda = 1'b0; wait_clk(Q);
        ctl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        ctl_sda = 1'b0; wait_clk(Q);
        ctl_scl = 1'b1; wait_clk(Q);
        ctl_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic wr_bit(input logic b);
        ctl_sda = b;    wait_clk(Q);
        ctl_scl = 1'b1; wait_clk(2 * Q);
        ctl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic rd_bit(output logic b);
        ctl_sda = 1'b1; wait_clk(Q);
        ctl_scl = 1'b1; wait_clk(Q);
        b = sda_bus;    wait_clk(Q);
        ctl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack_n);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack);
    endtask

    // Register contents as the controller should see them for one read burst.
    task automatic take_snap();
        m_snap[0] = {1'b0, life};
        m_snap[1] = {1'b0, food};
        m_snap[2] = {1'b0, fun};
        m_snap[3] = {1'b0, rest};
        m_snap[4] = {6'b0, death, disease};
        m_snap[5] = {1'b0, medicines};
        m_snap[6] = m_cmd;
        m_snap[7] = 8'hA5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        tests++; if (bus.sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got %b exp 0", bus.sda_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
        tests++; if (cmd_data !== 8'h00) begin fails++; $display("FAIL reset_cmd_data got %h exp 00", cmd_data); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_basic_read();
        logic a0, a1, a2;
        logic [7:0] d;
        life = 7'd100;
        i2c_start();
        wr_byte(8'h84, a0);
        wr_byte(8'h00, a1);
        m_ptr = 3'd0;
        i2c_start();
        take_snap();
        wr_byte(8'h85, a2);
        rd_byte(1'b1, d);
        tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL basic_acks got %b exp 000", {a0, a1, a2}); end
        tests++; if (d !== 8'h64) begin fails++; $display("FAIL basic_data got %h exp 64", d); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_before_stop got %b exp 1", busy); end
        i2c_stop();
        wait_clk(Q);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after_stop got %b exp 0", busy); end
        tests++; if (bus.sda_oe !== 1'b0) begin fails++; $display("FAIL basic_sda_oe_after got %b exp 0", bus.sda_oe); end
    endtask

    task automatic test_burst_snapshot();
        logic a, acc;
        logic [7:0] d;
        logic [7:0] exp_b [5];
        exp_b = '{8'h01, 8'h03, 8'h00, 8'hA5, 8'h64};
        life = 7'd100; disease = 1'b1; death = 1'b0; medicines = 7'd3;
        acc = 1'b0;
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h04, a); acc |= a;
        m_ptr = 3'd4;
        i2c_start();
        take_snap();
        wr_byte(8'h85, a); acc |= a;
        for (int k = 0; k < 5; k++) begin
            rd_byte(k == 4, d);
            if (k == 1) life = 7'd50;
            tests++; if (d !== exp_b[k]) begin fails++; $display("FAIL burst_byte%0d got %h exp %h", k, d, exp_b[k]); end
            if (k != 4) m_ptr = m_ptr + 3'd1;
        end
        i2c_stop();
        tests++; if (acc !== 1'b0) begin fails++; $display("FAIL burst_acks got nack exp ack"); end
    endtask

    task automatic test_cmd_write();
        logic a, acc;
        logic [7:0] d;
        int cv0;
        acc = 1'b0;
        cv0 = cv_cnt;
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h06, a); acc |= a;
        wr_byte(8'h02, a); acc |= a;
        i2c_stop();
        m_cmd = 8'h02; m_ptr = 3'd7;
        wait_clk(Q);
        tests++; if (cv_cnt - cv0 !== 1) begin fails++; $display("FAIL cmd_pulses got %0d exp 1", cv_cnt - cv0); end
        tests++; if (cmd_data !== 8'h02) begin fails++; $display("FAIL cmd_data got %h exp 02", cmd_data); end
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h06, a); acc |= a;
        m_ptr = 3'd6;
        i2c_start();
        take_snap();
        wr_byte(8'h85, a); acc |= a;
        rd_byte(1'b1, d);
        i2c_stop();
        tests++; if (d !== 8'h02) begin fails++; $display("FAIL cmd_readback got %h exp 02", d); end
        tests++; if (acc !== 1'b0) begin fails++; $display("FAIL cmd_acks got nack exp ack"); end
    endtask

    task automatic test_bad_addr();
        logic a, ack_bad;
        logic [7:0] d;
        int cv0;
        rest = 7'h11;
        cv0 = cv_cnt;
        wait_clk(2);
        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h86, ack_bad);
        wr_byte(8'h03, a);
        wr_byte(8'h5A, a);
        i2c_stop();
        wait_clk(Q);
        tests++; if (ack_bad !== 1'b1) begin fails++; $display("FAIL badaddr_ack got %b exp 1", ack_bad); end
        tests++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL badaddr_sda_oe got %b exp 0", oe_seen); end
        tests++; if (cv_cnt !== cv0) begin fails++; $display("FAIL badaddr_cmd_valid got %0d exp %0d", cv_cnt, cv0); end
        // Read without setting the pointer: must still be where the last good write left it.
        i2c_start();
        take_snap();
        wr_byte(8'h85, a);
        rd_byte(1'b1, d);
        i2c_stop();
        tests++; if (d !== m_snap[m_ptr]) begin fails++; $display("FAIL badaddr_ptr_kept got %h exp %h", d, m_snap[m_ptr]); end
    endtask

    task automatic test_glitch_abort();
        logic a, acc;
        logic [7:0] d, adr;
        adr = 8'h84;
        food = 7'h2B; medicines = 7'h3C;
        acc = 1'b0;
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            wr_bit(adr[i]);
            if (i == 4) begin
                ctl_scl = 1'b1; wait_clk(FILTER_LEN - 1);
                ctl_scl = 1'b0; wait_clk(Q);
            end
        end
        rd_bit(a); acc |= a;
        wr_byte(8'h01, a); acc |= a;
        m_ptr = 3'd1;
        i2c_start();
        take_snap();
        wr_byte(8'h85, a); acc |= a;
        rd_byte(1'b1, d);
        i2c_stop();
        tests++; if (d !== {1'b0, food}) begin fails++; $display("FAIL glitch_data got %h exp %h", d, {1'b0, food}); end
        tests++; if (acc !== 1'b0) begin fails++; $display("FAIL glitch_acks got nack exp ack"); end
        i2c_start();
        for (int i = 7; i >= 4; i--) wr_bit(adr[i]);
        i2c_stop();
        wait_clk(Q);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
        acc = 1'b0;
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h05, a); acc |= a;
        m_ptr = 3'd5;
        i2c_start();
        take_snap();
        wr_byte(8'h85, a); acc |= a;
        for (int k = 0; k < 2; k++) begin
            rd_byte(k == 1, d);
            tests++; if (d !== m_snap[m_ptr]) begin fails++; $display("FAIL abort_read%0d got %h exp %h", k, d, m_snap[m_ptr]); end
            if (k == 0) m_ptr = m_ptr + 3'd1;
        end
        i2c_stop();
        tests++; if (acc !== 1'b0) begin fails++; $display("FAIL abort_acks got nack exp ack"); end
    endtask

    task automatic test_random();
        logic a, acc;
        logic [7:0] d, c;
        logic [2:0] p;
        int n, cv0, cv_exp;
        for (int it = 0; it < 10; it++) begin
            life = 7'($urandom); food = 7'($urandom); fun = 7'($urandom);
            rest = 7'($urandom); medicines = 7'($urandom);
            disease = 1'($urandom); death = 1'($urandom);
            acc = 1'b0;
            cv0 = cv_cnt; cv_exp = 0;
            if ($urandom_range(1, 0) == 1) begin
                c = 8'($urandom);
                i2c_start();
                wr_byte(8'h84, a); acc |= a;
                wr_byte({5'($urandom), 3'd6}, a); acc |= a;
                wr_byte(c, a); acc |= a;
                wr_byte(8'($urandom), a); acc |= a;   // lands on the read-only ID register
                i2c_stop();
                m_cmd = c; cv_exp = 1; m_ptr = 3'd0;
            end
            p = 3'($urandom);
            n = $urandom_range(4, 1);
            i2c_start();
            wr_byte(8'h84, a); acc |= a;
            wr_byte({5'($urandom), p}, a); acc |= a;
            m_ptr = p;
            i2c_start();
            take_snap();
            wr_byte(8'h85, a); acc |= a;
            for (int k = 0; k < n; k++) begin
                rd_byte(k == n - 1, d);
                tests++; if (d !== m_snap[m_ptr]) begin fails++; $display("FAIL rand%0d_reg%0d got %h exp %h", it, m_ptr, d, m_snap[m_ptr]); end
                if (k != n - 1) m_ptr = m_ptr + 3'd1;
            end
            i2c_stop();
            wait_clk(Q);
            tests++; if (acc !== 1'b0) begin fails++; $display("FAIL rand%0d_acks got nack exp ack", it); end
            tests++; if (cmd_data !== m_cmd) begin fails++; $display("FAIL rand%0d_cmd_data got %h exp %h", it, cmd_data, m_cmd); end
            tests++; if (cv_cnt - cv0 !== cv_exp) begin fails++; $display("FAIL rand%0d_pulses got %0d exp %0d", it, cv_cnt - cv0, cv_exp); end
        end
    endtask

    task automatic test_reset_midread();
        logic a, acc;
        logic [7:0] d;
        acc = 1'b0;
        life = 7'($urandom);
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h00, a); acc |= a;
        i2c_start();
        wr_byte(8'h85, a); acc |= a;
        // Status registers are 7-bit, so bit 7 of the read byte is 0 and SDA is held low.
        tests++; if (bus.sda_oe !== 1'b1) begin fails++; $display("FAIL midread_driving got %b exp 1", bus.sda_oe); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.sda_oe !== 1'b0) begin fails++; $display("FAIL midread_async_release got %b exp 0", bus.sda_oe); end
        ctl_scl = 1'b1; ctl_sda = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        m_ptr = 3'd0; m_cmd = 8'h00;
        tests++; if (cmd_data !== 8'h00) begin fails++; $display("FAIL postreset_cmd_data got %h exp 00", cmd_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL postreset_busy got %b exp 0", busy); end
        i2c_start();
        take_snap();
        wr_byte(8'h85, a); acc |= a;
        rd_byte(1'b1, d);
        i2c_stop();
        tests++; if (d !== m_snap[0]) begin fails++; $display("FAIL postreset_ptr0 got %h exp %h", d, m_snap[0]); end
        i2c_start();
        wr_byte(8'h84, a); acc |= a;
        wr_byte(8'h06, a); acc |= a;
        i2c_start();
        wr_byte(8'h85, a); acc |= a;
        rd_byte(1'b1, d);
        i2c_stop();
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL postreset_cmd_reg got %h exp 00", d); end
        tests++; if (acc !== 1'b0) begin fails++; $display("FAIL postreset_acks got nack exp ack"); end
    endtask

    initial begin
        life = 7'd0; food = 7'd0; fun = 7'd0; rest = 7'd0; medicines = 7'd0;
        disease = 1'b0; death = 1'b0;
        test_reset();
        test_basic_read();
        test_burst_snapshot();
        test_cmd_write();
        test_bad_addr();
        test_glitch_abort();
        test_random();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
